// File: rtl/cla_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package cla_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  // The cla exposes no carry-out; rebuild it from the MSB inputs and sum bit.
  function automatic logic carry_from_msb(input logic a31, input logic b31, input logic s31);
    return (a31 & b31) | ((a31 ^ b31) & ~s31);
  endfunction

endpackage

// File: rtl/cla_mp_sequencer_if.sv
// Request/response handshake bundle between a requester and the sequencer.
interface cla_mp_sequencer_if #(
  parameter int unsigned WORDS = 2
) ();
  import cla_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [WORDS*WORD_W-1:0]   in_a;
  logic [WORDS*WORD_W-1:0]   in_b;
  logic                      in_sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORDS*WORD_W-1:0]   out_sum;
  logic                      out_cout;
  logic                      out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/cla.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups; sum only.
module cla
  import cla_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_sum_c
);

  localparam int unsigned GRP_W = 4;
  localparam int unsigned N_GRP = WORD_W / GRP_W;

  logic [WORD_W-1:0] w_g;
  logic [WORD_W-1:0] w_p;
  logic [WORD_W-1:0] w_c;
  logic              w_cg;

  // Carries inside a group are fully expanded; group carries chain via G/P.
  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_c  = '0;
    w_cg = i_cin;
    for (int k = 0; k < N_GRP; k++) begin
      w_c[k*GRP_W]     = w_cg;
      w_c[k*GRP_W + 1] = w_g[k*GRP_W] | (w_p[k*GRP_W] & w_cg);
      w_c[k*GRP_W + 2] = w_g[k*GRP_W + 1]
                       | (w_p[k*GRP_W + 1] & w_g[k*GRP_W])
                       | (w_p[k*GRP_W + 1] & w_p[k*GRP_W] & w_cg);
      w_c[k*GRP_W + 3] = w_g[k*GRP_W + 2]
                       | (w_p[k*GRP_W + 2] & w_g[k*GRP_W + 1])
                       | (w_p[k*GRP_W + 2] & w_p[k*GRP_W + 1] & w_g[k*GRP_W])
                       | (w_p[k*GRP_W + 2] & w_p[k*GRP_W + 1] & w_p[k*GRP_W] & w_cg);
      w_cg = w_g[k*GRP_W + 3]
           | (w_p[k*GRP_W + 3] & w_g[k*GRP_W + 2])
           | (w_p[k*GRP_W + 3] & w_p[k*GRP_W + 2] & w_g[k*GRP_W + 1])
           | (w_p[k*GRP_W + 3] & w_p[k*GRP_W + 2] & w_p[k*GRP_W + 1] & w_g[k*GRP_W])
           | (w_p[k*GRP_W + 3] & w_p[k*GRP_W + 2] & w_p[k*GRP_W + 1] & w_p[k*GRP_W] & w_cg);
    end
    o_sum_c = w_p ^ w_c;
  end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract: streams WORDS 32-bit words LSW-first through one cla,
// carrying between words in a register.
module cla_mp_sequencer
  import cla_pkg::*;
#(
  parameter int unsigned WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_mp_sequencer_if.slave    bus
);

  localparam int unsigned      IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  mp_state_t                    r_state;
  mp_state_t                    w_state_nxt;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_carry;
  logic                         r_cout;
  logic                         r_ovf;
  logic [WORDS-1:0][WORD_W-1:0] r_a;
  logic [WORDS-1:0][WORD_W-1:0] r_b;
  logic [WORDS-1:0][WORD_W-1:0] r_sum;

  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_sum_word;
  logic              w_carry_nxt;
  logic              w_accept;
  logic              w_step;
  logic              w_last;

  assign w_a_word = r_a[r_idx];
  assign w_b_word = r_b[r_idx];

  cla u_cla (
    .i_a     (w_a_word),
    .i_b     (w_b_word),
    .i_cin   (r_carry),
    .o_sum_c (w_sum_word)
  );

  assign w_carry_nxt = carry_from_msb(w_a_word[WORD_W-1], w_b_word[WORD_W-1],
                                      w_sum_word[WORD_W-1]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-word sum/carry update, and final flags on the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.in_a;
        r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
        r_carry <= bus.in_sub;
        r_idx   <= '0;
      end
      if (w_step) begin
        r_sum[r_idx] <= w_sum_word;
        r_carry      <= w_carry_nxt;
        r_idx        <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_cout <= w_carry_nxt;
        r_ovf  <= (r_a[WORDS-1][WORD_W-1] == r_b[WORDS-1][WORD_W-1]) &&
                  (w_sum_word[WORD_W-1] != r_a[WORDS-1][WORD_W-1]);
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer with a cycle-level reference model.
module tb_cla_mp_sequencer;

  localparam int unsigned WORDS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_mp_sequencer_if #(.WORDS(WORDS)) bus ();

  cla_mp_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: cycles since accept (-1 = idle); result is full-width arithmetic.
  int          m_since = -1;
  bit          m_live  = 1'b0;
  bit          m_acc   = 1'b0;
  logic [63:0] m_sum   = '0;
  bit          m_cout  = 1'b0;
  bit          m_ovf   = 1'b0;
  logic [63:0] p_sum;
  bit          p_cout;
  bit          p_ovf;

  always @(posedge clk) begin
    logic [64:0] t;
    logic [63:0] bp;
    m_acc = 1'b0;
    if (rst) begin
      m_live  = 1'b1;
      m_since = -1;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_live) begin
      if (m_since < 0) begin
        if (bus.in_valid) begin
          bp      = bus.in_sub ? ~bus.in_b : bus.in_b;
          t       = {1'b0, bus.in_a} + {1'b0, bp} + 65'(bus.in_sub);
          p_sum   = t[63:0];
          p_cout  = t[64];
          p_ovf   = (bus.in_a[63] == bp[63]) && (p_sum[63] != bus.in_a[63]);
          m_since = 0;
          m_acc   = 1'b1;
        end
      end else if (m_since < int'(WORDS)) begin
        m_since++;
        if (m_since == int'(WORDS)) begin
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
        end
      end else if (bus.out_ready) begin
        m_since = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("mdl_in_ready", bus.in_ready, m_since < 0);
      chk("mdl_out_valid", bus.out_valid, m_since == int'(WORDS));
      if (m_since < 0 || m_since == int'(WORDS)) begin
        chk("mdl_out_sum", bus.out_sum, m_sum);
        chk("mdl_out_cout", bus.out_cout, m_cout);
        chk("mdl_out_ovf", bus.out_ovf, m_ovf);
      end
    end
  end

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit sub);
    bit ok;
    ok          = 1'b0;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_sub  = sub;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) ok = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("accept_seen", ok, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input bit sub, input logic [63:0] e_sum, input bit e_cout,
                        input bit e_ovf);
    issue(a, b, sub);
    for (int i = 1; i < int'(WORDS); i++) begin
      @(negedge clk);
      chk({name, "_early_valid"}, bus.out_valid, 1'b0);
    end
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_sum"}, bus.out_sum, e_sum);
    chk({name, "_cout"}, bus.out_cout, e_cout);
    chk({name, "_ovf"}, bus.out_ovf, e_ovf);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 64'h0000_0001_0000_0002;
    bus.in_b      = 64'h0000_0003_0000_0004;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.out_sum, 64'h0);
    chk("rst_cout", bus.out_cout, 1'b0);
    chk("rst_ovf", bus.out_ovf, 1'b0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    run_op("add_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("add_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Backpressure: result held while a new request waits.
    bus.out_ready = 1'b0;
    issue(64'h10, 64'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.in_a     = 64'h3;
    bus.in_b     = 64'h4;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_sum", bus.out_sum, 64'h30);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", bus.in_ready, 1'b1);
    chk("bp_idle_valid", bus.out_valid, 1'b0);
    chk("bp_stale_sum", bus.out_sum, 64'h30);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_new_taken", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("bp_new_early", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("bp_new_valid", bus.out_valid, 1'b1);
    chk("bp_new_sum", bus.out_sum, 64'h7);
    @(negedge clk);

    // Reset during the first RUN cycle aborts the operation.
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", bus.in_ready, 1'b1);
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_sum", bus.out_sum, 64'h0);
    chk("midrst_cout", bus.out_cout, 1'b0);
    chk("midrst_ovf", bus.out_ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", bus.out_valid, 1'b0);
    end
    run_op("add_5_7", 64'h5, 64'h7, 1'b0, 64'hC, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
